// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding imem request, IF/ID register with stall hold and redirect flush.
// Optional FETCH_PERF_EN macro adds perf_fetched / perf_stall counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst_f,
    output logic [31:0] pc_f,
    output logic        valid_f
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
`endif
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DROP  = 2'd2
    } state_t;

    state_t      state_reg;
    logic [31:0] pc_reg;
    logic [31:0] target_reg;
    logic [31:0] buf_inst_reg;

    logic [31:0] redirect_target;
    logic [31:0] pc_plus4;

    assign redirect_target = redirect_pc & ~32'h3;
    assign pc_plus4        = pc_reg + 32'd4;

    // Address is the current PC in every state; in DROP that is still the old, abandoned address.
    assign imem_req  = !rst && (state_reg != ST_HOLD);
    assign imem_addr = pc_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_FETCH;
            pc_reg       <= RESET_PC & ~32'h3;
            target_reg   <= RESET_PC & ~32'h3;
            buf_inst_reg <= 32'h0;
            inst_f       <= 32'h0;
            pc_f         <= RESET_PC & ~32'h3;
            valid_f      <= 1'b0;
        end else begin
            case (state_reg)
                ST_FETCH: begin
                    if (redirect_valid) begin
                        inst_f  <= 32'h0;
                        valid_f <= 1'b0;
                        if (imem_ready) begin
                            pc_reg <= redirect_target;
                        end else begin
                            // The old request is still in flight; remember where to go once it lands.
                            target_reg <= redirect_target;
                            state_reg  <= ST_DROP;
                        end
                    end else if (imem_ready) begin
                        if (stall) begin
                            buf_inst_reg <= imem_rdata;
                            state_reg    <= ST_HOLD;
                        end else begin
                            inst_f  <= imem_rdata;
                            pc_f    <= pc_reg;
                            valid_f <= 1'b1;
                            pc_reg  <= pc_plus4;
                        end
                    end else if (!stall) begin
                        inst_f  <= 32'h0;
                        valid_f <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (redirect_valid) begin
                        inst_f       <= 32'h0;
                        valid_f      <= 1'b0;
                        pc_reg       <= redirect_target;
                        buf_inst_reg <= 32'h0;
                        state_reg    <= ST_FETCH;
                    end else if (!stall) begin
                        // pc_reg was held while buffered, so it is the PC of the buffered word.
                        inst_f       <= buf_inst_reg;
                        pc_f         <= pc_reg;
                        valid_f      <= 1'b1;
                        pc_reg       <= pc_plus4;
                        buf_inst_reg <= 32'h0;
                        state_reg    <= ST_FETCH;
                    end
                end
                ST_DROP: begin
                    inst_f  <= 32'h0;
                    valid_f <= 1'b0;
                    if (imem_ready) begin
                        pc_reg    <= redirect_valid ? redirect_target : target_reg;
                        state_reg <= ST_FETCH;
                    end else if (redirect_valid) begin
                        target_reg <= redirect_target;
                    end
                end
                default: begin
                    state_reg <= ST_FETCH;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    logic load_fire;

    assign load_fire = !redirect_valid && !stall &&
                       (((state_reg == ST_FETCH) && imem_ready) || (state_reg == ST_HOLD));

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched <= 32'h0;
            perf_stall   <= 32'h0;
        end else begin
            if (load_fire) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (state_reg == ST_HOLD) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; one task per scenario, expected values hand-computed.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] inst_f;
    logic [31:0] pc_f;
    logic        valid_f;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    fetch_stage #(.RESET_PC(32'hBFC0_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .inst_f         (inst_f),
        .pc_f           (pc_f),
        .valid_f        (valid_f)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_stall     (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1ns so registered outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        $display("cyc=%0d req=%b addr=%h valid_f=%b pc_f=%h inst_f=%h", cyc, imem_req, imem_addr, valid_f, pc_f, inst_f);
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        imem_ready = 1'b1; imem_rdata = 32'hFFFF_FFFF;
        tick();
        tick();
        compared++; if (imem_req !== 1'b0) begin mismatched++; $display("FAIL reset_req got %b want %b", imem_req, 1'b0); end
        compared++; if (imem_addr !== 32'hBFC0_0000) begin mismatched++; $display("FAIL reset_addr got %h want %h", imem_addr, 32'hBFC0_0000); end
        compared++; if (pc_f !== 32'hBFC0_0000) begin mismatched++; $display("FAIL reset_pc_f got %h want %h", pc_f, 32'hBFC0_0000); end
        compared++; if (inst_f !== 32'h0) begin mismatched++; $display("FAIL reset_inst_f got %h want %h", inst_f, 32'h0); end
        compared++; if (valid_f !== 1'b0) begin mismatched++; $display("FAIL reset_valid_f got %b want %b", valid_f, 1'b0); end
`ifdef FETCH_PERF_EN
        compared++; if (perf_fetched !== 32'h0) begin mismatched++; $display("FAIL reset_perf_fetched got %0d want 0", perf_fetched); end
        compared++; if (perf_stall !== 32'h0) begin mismatched++; $display("FAIL reset_perf_stall got %0d want 0", perf_stall); end
`endif
    endtask

    task automatic test_sequential();
        rst = 1'b0; imem_ready = 1'b1; imem_rdata = 32'h2401_0001;
        #1;
        compared++; if (imem_req !== 1'b1) begin mismatched++; $display("FAIL seq_first_req got %b want %b", imem_req, 1'b1); end
        compared++; if (imem_addr !== 32'hBFC0_0000) begin mismatched++; $display("FAIL seq_first_addr got %h want %h", imem_addr, 32'hBFC0_0000); end
        tick();
        compared++; if (pc_f !== 32'hBFC0_0000) begin mismatched++; $display("FAIL seq_pc_f0 got %h want %h", pc_f, 32'hBFC0_0000); end
        compared++; if (inst_f !== 32'h2401_0001) begin mismatched++; $display("FAIL seq_inst_f0 got %h want %h", inst_f, 32'h2401_0001); end
        compared++; if (valid_f !== 1'b1) begin mismatched++; $display("FAIL seq_valid0 got %b want %b", valid_f, 1'b1); end
        compared++; if (imem_addr !== 32'hBFC0_0004) begin mismatched++; $display("FAIL seq_addr1 got %h want %h", imem_addr, 32'hBFC0_0004); end
        imem_rdata = 32'h2402_0002;
        tick();
        compared++; if (pc_f !== 32'hBFC0_0004) begin mismatched++; $display("FAIL seq_pc_f1 got %h want %h", pc_f, 32'hBFC0_0004); end
        compared++; if (inst_f !== 32'h2402_0002) begin mismatched++; $display("FAIL seq_inst_f1 got %h want %h", inst_f, 32'h2402_0002); end
        compared++; if (valid_f !== 1'b1) begin mismatched++; $display("FAIL seq_valid1 got %b want %b", valid_f, 1'b1); end
        compared++; if (imem_addr !== 32'hBFC0_0008) begin mismatched++; $display("FAIL seq_addr2 got %h want %h", imem_addr, 32'hBFC0_0008); end
    endtask

    task automatic test_stall_no_word();
        stall = 1'b1; imem_ready = 1'b0; imem_rdata = 32'hDEAD_0000;
        tick();
        compared++; if (pc_f !== 32'hBFC0_0004) begin mismatched++; $display("FAIL nw_pc_f got %h want %h", pc_f, 32'hBFC0_0004); end
        compared++; if (inst_f !== 32'h2402_0002) begin mismatched++; $display("FAIL nw_inst_f got %h want %h", inst_f, 32'h2402_0002); end
        compared++; if (valid_f !== 1'b1) begin mismatched++; $display("FAIL nw_valid got %b want %b", valid_f, 1'b1); end
        compared++; if (imem_addr !== 32'hBFC0_0008) begin mismatched++; $display("FAIL nw_addr got %h want %h", imem_addr, 32'hBFC0_0008); end
        compared++; if (imem_req !== 1'b1) begin mismatched++; $display("FAIL nw_req got %b want %b", imem_req, 1'b1); end
    endtask

    task automatic test_stall_hold();
        stall = 1'b1; imem_ready = 1'b1; imem_rdata = 32'h2403_0003;
        tick();
        imem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) stall = 1'b0;
            #1;
            compared++; if (imem_req !== 1'b0) begin mismatched++; $display("FAIL hold_req[%0d] got %b want %b", i, imem_req, 1'b0); end
            compared++; if (pc_f !== 32'hBFC0_0004) begin mismatched++; $display("FAIL hold_pc_f[%0d] got %h want %h", i, pc_f, 32'hBFC0_0004); end
            compared++; if (inst_f !== 32'h2402_0002) begin mismatched++; $display("FAIL hold_inst_f[%0d] got %h want %h", i, inst_f, 32'h2402_0002); end
            tick();
        end
        compared++; if (pc_f !== 32'hBFC0_0008) begin mismatched++; $display("FAIL hold_rel_pc_f got %h want %h", pc_f, 32'hBFC0_0008); end
        compared++; if (inst_f !== 32'h2403_0003) begin mismatched++; $display("FAIL hold_rel_inst_f got %h want %h", inst_f, 32'h2403_0003); end
        compared++; if (valid_f !== 1'b1) begin mismatched++; $display("FAIL hold_rel_valid got %b want %b", valid_f, 1'b1); end
        compared++; if (imem_addr !== 32'hBFC0_000C) begin mismatched++; $display("FAIL hold_rel_addr got %h want %h", imem_addr, 32'hBFC0_000C); end
        compared++; if (imem_req !== 1'b1) begin mismatched++; $display("FAIL hold_rel_req got %b want %b", imem_req, 1'b1); end
`ifdef FETCH_PERF_EN
        compared++; if (perf_stall !== 32'd3) begin mismatched++; $display("FAIL perf_stall got %0d want 3", perf_stall); end
        compared++; if (perf_fetched !== 32'd3) begin mismatched++; $display("FAIL perf_fetched got %0d want 3", perf_fetched); end
`endif
    endtask

    task automatic test_redirect_drop();
        imem_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0040_0003;
        tick();
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        compared++; if (valid_f !== 1'b0) begin mismatched++; $display("FAIL drop_valid0 got %b want %b", valid_f, 1'b0); end
        compared++; if (inst_f !== 32'h0) begin mismatched++; $display("FAIL drop_inst0 got %h want %h", inst_f, 32'h0); end
        compared++; if (imem_addr !== 32'hBFC0_000C) begin mismatched++; $display("FAIL drop_addr0 got %h want %h", imem_addr, 32'hBFC0_000C); end
        compared++; if (imem_req !== 1'b1) begin mismatched++; $display("FAIL drop_req0 got %b want %b", imem_req, 1'b1); end
        tick();
        compared++; if (imem_addr !== 32'hBFC0_000C) begin mismatched++; $display("FAIL drop_addr1 got %h want %h", imem_addr, 32'hBFC0_000C); end
        imem_ready = 1'b1; imem_rdata = 32'hBADB_AD00;
        tick();
        compared++; if (valid_f !== 1'b0) begin mismatched++; $display("FAIL drop_stale_valid got %b want %b", valid_f, 1'b0); end
        compared++; if (imem_addr !== 32'h0040_0000) begin mismatched++; $display("FAIL drop_target_addr got %h want %h", imem_addr, 32'h0040_0000); end
        imem_rdata = 32'h1111_1111;
        tick();
        compared++; if (pc_f !== 32'h0040_0000) begin mismatched++; $display("FAIL drop_new_pc_f got %h want %h", pc_f, 32'h0040_0000); end
        compared++; if (inst_f !== 32'h1111_1111) begin mismatched++; $display("FAIL drop_new_inst got %h want %h", inst_f, 32'h1111_1111); end
        compared++; if (valid_f !== 1'b1) begin mismatched++; $display("FAIL drop_new_valid got %b want %b", valid_f, 1'b1); end
    endtask

    task automatic test_redirect_in_hold();
        stall = 1'b1; imem_ready = 1'b1; imem_rdata = 32'h2222_2222;
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h0080_0000;
        tick();
        redirect_valid = 1'b0; stall = 1'b0;
        compared++; if (valid_f !== 1'b0) begin mismatched++; $display("FAIL rh_valid got %b want %b", valid_f, 1'b0); end
        compared++; if (inst_f !== 32'h0) begin mismatched++; $display("FAIL rh_inst got %h want %h", inst_f, 32'h0); end
        compared++; if (imem_addr !== 32'h0080_0000) begin mismatched++; $display("FAIL rh_addr got %h want %h", imem_addr, 32'h0080_0000); end
        compared++; if (imem_req !== 1'b1) begin mismatched++; $display("FAIL rh_req got %b want %b", imem_req, 1'b1); end
        imem_rdata = 32'h3333_3333;
        tick();
        compared++; if (pc_f !== 32'h0080_0000) begin mismatched++; $display("FAIL rh_next_pc_f got %h want %h", pc_f, 32'h0080_0000); end
        compared++; if (inst_f !== 32'h3333_3333) begin mismatched++; $display("FAIL rh_next_inst got %h want %h", inst_f, 32'h3333_3333); end
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; imem_ready = 1'b1;
        tick();
        redirect_valid = 1'b0;
        compared++; if (imem_addr !== 32'hFFFF_FFFC) begin mismatched++; $display("FAIL wrap_addr0 got %h want %h", imem_addr, 32'hFFFF_FFFC); end
        imem_rdata = 32'h4444_4444;
        tick();
        compared++; if (pc_f !== 32'hFFFF_FFFC) begin mismatched++; $display("FAIL wrap_pc_f got %h want %h", pc_f, 32'hFFFF_FFFC); end
        compared++; if (imem_addr !== 32'h0000_0000) begin mismatched++; $display("FAIL wrap_next_addr got %h want %h", imem_addr, 32'h0000_0000); end
    endtask

    task automatic test_reset_in_drop();
        imem_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_1000;
        tick();
        redirect_valid = 1'b0;
        compared++; if (imem_addr !== 32'h0000_0000) begin mismatched++; $display("FAIL rd_drop_addr got %h want %h", imem_addr, 32'h0000_0000); end
        rst = 1'b1;
        #1;
        compared++; if (imem_req !== 1'b0) begin mismatched++; $display("FAIL rd_req_in_rst got %b want %b", imem_req, 1'b0); end
        tick();
        rst = 1'b0;
        #1;
        compared++; if (imem_addr !== 32'hBFC0_0000) begin mismatched++; $display("FAIL rd_addr got %h want %h", imem_addr, 32'hBFC0_0000); end
        compared++; if (valid_f !== 1'b0) begin mismatched++; $display("FAIL rd_valid got %b want %b", valid_f, 1'b0); end
        compared++; if (imem_req !== 1'b1) begin mismatched++; $display("FAIL rd_first_req got %b want %b", imem_req, 1'b1); end
        imem_ready = 1'b1; imem_rdata = 32'h5555_5555;
        tick();
        compared++; if (pc_f !== 32'hBFC0_0000) begin mismatched++; $display("FAIL rd_pc_f got %h want %h", pc_f, 32'hBFC0_0000); end
        compared++; if (inst_f !== 32'h5555_5555) begin mismatched++; $display("FAIL rd_inst got %h want %h", inst_f, 32'h5555_5555); end
        compared++; if (valid_f !== 1'b1) begin mismatched++; $display("FAIL rd_valid1 got %b want %b", valid_f, 1'b1); end
    endtask

    initial begin
        #20000;
        mismatched++;
        $display("FAIL watchdog_timeout got running want finished");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_sequential();
        test_stall_no_word();
        test_stall_hold();
        test_redirect_drop();
        test_redirect_in_hold();
        test_wrap();
        test_reset_in_drop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter: RESET_PC, 32'hBFC0_0000, PC loaded on reset; bits [1:0] SHALL be 0.
REQ-002 Port: clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 Port: rst  in  1  reset, synchronous and active-high.
REQ-004 Port: stall  in  1  decode-side hold; the IF/ID outputs SHALL be frozen while high.
REQ-005 Port: redirect_valid  in  1  branch or jump taken; redirect_pc is the new fetch target.
REQ-006 Port: redirect_pc  in  32  target address; bits [1:0] SHALL be ignored and treated as 0.
REQ-007 Port: imem_req  out  1  instruction memory request.
REQ-008 Port: imem_addr  out  32  request address; SHALL be stable while imem_req=1 and imem_ready=0.
REQ-009 Port: imem_ready  in  1  response strobe; it MAY be high in the same cycle as the request.
REQ-010 Port: imem_rdata  in  32  instruction word; valid only when imem_ready=1.
REQ-011 Port: inst_f  out  32  registered instruction to decode; SHALL be 32'h0 (NOP) whenever valid_f=0.
REQ-012 Port: pc_f  out  32  registered PC of inst_f.
REQ-013 Port: valid_f  out  1  inst_f/pc_f carry a real instruction.

Function
REQ-014 States SHALL be FETCH (request outstanding), HOLD (word buffered, stalled) and DROP (draining a stale response); at most one request outstanding.
REQ-015 imem_req SHALL be 1 in FETCH and DROP, 0 in HOLD and whenever rst=1; imem_addr SHALL equal pc_q.
REQ-016 FETCH, imem_ready=1, stall=0, no redirect: inst_f<=imem_rdata, pc_f<=pc_q, valid_f<=1, pc_q<=pc_q+4, stay FETCH.
REQ-017 FETCH, imem_ready=1, stall=1, no redirect: buffer imem_rdata and pc_q, hold IF/ID, go to HOLD.
REQ-018 HOLD, stall=0, no redirect: IF/ID<=buffer with valid_f=1, pc_q<=pc_q+4, go to FETCH.
REQ-019 stall=1 with no word accepted: IF/ID and pc_q SHALL be held.
REQ-020 redirect_valid SHALL take priority over stall: pc_q<=redirect_pc, valid_f<=0, inst_f<=0, and any buffered word is discarded.
REQ-021 Redirect in FETCH with imem_ready=1, or in HOLD: the word is discarded and the next state is FETCH at the target.
REQ-022 Redirect in FETCH with imem_ready=0: go to DROP, keep requesting the old address until imem_ready=1, then discard the data and go to FETCH at the target.
REQ-023 A further redirect during DROP SHALL overwrite the target; redirect during DROP with imem_ready=1 SHALL go to FETCH at the newest target.
REQ-024 PC arithmetic SHALL be modulo 2^32: 32'hFFFF_FFFC+4 = 32'h0.
REQ-025 With a zero-wait memory (imem_ready tied 1) and no stall, throughput SHALL be one instruction per cycle, with inst_f appearing one cycle after its request.

Reset
REQ-026 While rst=1: state=FETCH, pc_q=RESET_PC, pc_f=RESET_PC, inst_f=0, valid_f=0, buffer cleared, imem_req=0.
REQ-027 Reset mid-operation SHALL abandon any outstanding request or buffered word; the first request (addr RESET_PC) SHALL be issued in the first cycle with rst=0.

Configuration
REQ-028 Macro FETCH_PERF_EN: when defined, add outputs perf_fetched (32) and perf_stall (32), both reset to 0.
REQ-029 perf_fetched SHALL count words loaded into IF/ID with valid_f=1; perf_stall SHALL count cycles in HOLD.
REQ-030 Both counters SHALL wrap at 2^32.
REQ-031 Without FETCH_PERF_EN, the ports and counters SHALL be absent and behaviour otherwise identical.

Verification
REQ-032 Reset release, imem_ready=1, words 0x24010001,0x24020002 -> pc_f 0xBFC00000 then 0xBFC00004 on consecutive cycles, valid_f=1.
REQ-033 Response accepted with stall=1 for 3 cycles -> imem_req=0 for 3 cycles, IF/ID frozen, buffered word appears the cycle after stall drops, perf_stall=3.
REQ-034 Redirect to 0x00400000 while imem_ready=0 for 2 cycles -> imem_addr holds the old PC until ready, the stale word never reaches valid_f, next request is at 0x00400000.
REQ-035 Redirect and stall both asserted in HOLD -> valid_f=0, inst_f=0, next imem_addr=redirect_pc.
REQ-036 pc_q=0xFFFFFFFC, word accepted -> next imem_addr=0x00000000.
REQ-037 rst asserted while in DROP -> next cycle state FETCH, imem_addr=RESET_PC, valid_f=0.
